// File: rtl/sine_pkg.sv
// Shared definitions for the sine analyzer: hysteresis FSM encoding and mid-scale helper.
package sine_pkg;

  typedef enum logic {
    SEEK_LOW  = 1'b0,
    SEEK_HIGH = 1'b1
  } state_e;

  function automatic int mid(input int size);
    return 1 << (size - 1);
  endfunction

endpackage

// File: rtl/sine_analyzer_crossing_detector.sv
// Hysteresis FSM that strobes `rise_o` combinationally on a valid rising mid-scale crossing.
module crossing_detector
  import sine_pkg::*;
#(
  parameter int SINE_SIZE = 12,
  parameter int HYST      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sample_valid_i,
  input  logic [SINE_SIZE-1:0] sample_i,
  input  logic                 force_low_i,
  output logic                 rise_o
);

  localparam logic [SINE_SIZE-1:0] TL = SINE_SIZE'(mid(SINE_SIZE) - HYST);
  localparam logic [SINE_SIZE-1:0] TH = SINE_SIZE'(mid(SINE_SIZE) + HYST);

  state_e state_q, state_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= SEEK_LOW;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rise_o  = 1'b0;
    if (sample_valid_i) begin
      unique case (state_q)
        SEEK_LOW:  if (sample_i < TL) state_d = SEEK_HIGH;
        SEEK_HIGH: if (sample_i >= TH) begin
          state_d = SEEK_LOW;
          rise_o  = 1'b1;
        end
        default:   state_d = SEEK_LOW;
      endcase
    end
    // Overflow only happens on non-crossing samples, so forcing never hides a rise.
    if (force_low_i) state_d = SEEK_LOW;
  end

endmodule

// File: rtl/sine_analyzer.sv
// Measures period, peak, trough and amplitude of each sine cycle delimited by rising crossings.
module sine_analyzer
  import sine_pkg::*;
#(
  parameter int SINE_SIZE   = 12,
  parameter int HYST        = 16,
  parameter int PERIOD_SIZE = 16,
  parameter int LOCK_TOL    = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   sample_valid_i,
  input  logic [SINE_SIZE-1:0]   sample_i,
  output logic [PERIOD_SIZE-1:0] period_o,
  output logic [SINE_SIZE-1:0]   peak_o,
  output logic [SINE_SIZE-1:0]   trough_o,
  output logic [SINE_SIZE-1:0]   amplitude_o,
  output logic                   result_valid_o,
  output logic                   locked_o,
  output logic                   overflow_o
);

  localparam logic [PERIOD_SIZE-1:0] PMAX = '1;
  localparam logic [PERIOD_SIZE-1:0] TOL  = PERIOD_SIZE'(LOCK_TOL);

  logic                   rise;
  logic                   ovf_now;
  logic [PERIOD_SIZE-1:0] diff;

  logic                   have_prev_q, have_prev_d;
  logic                   have_pp_q, have_pp_d;
  logic [PERIOD_SIZE-1:0] count_q, count_d;
  logic [PERIOD_SIZE-1:0] prev_period_q, prev_period_d;
  logic [SINE_SIZE-1:0]   run_max_q, run_max_d, run_min_q, run_min_d;
  logic [PERIOD_SIZE-1:0] period_q, period_d;
  logic [SINE_SIZE-1:0]   peak_q, peak_d, trough_q, trough_d, amp_q, amp_d;
  logic                   rv_q, rv_d, locked_q, locked_d, ovf_q, ovf_d;

  crossing_detector #(
    .SINE_SIZE (SINE_SIZE),
    .HYST      (HYST)
  ) u_xdet (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .sample_valid_i (sample_valid_i),
    .sample_i       (sample_i),
    .force_low_i    (ovf_now),
    .rise_o         (rise)
  );

  assign ovf_now = sample_valid_i && !rise && have_prev_q && (count_q == PMAX);
  assign diff    = (count_q >= prev_period_q) ? count_q - prev_period_q
                                              : prev_period_q - count_q;

  always_comb begin
    have_prev_d   = have_prev_q;
    have_pp_d     = have_pp_q;
    count_d       = count_q;
    prev_period_d = prev_period_q;
    run_max_d     = run_max_q;
    run_min_d     = run_min_q;
    period_d      = period_q;
    peak_d        = peak_q;
    trough_d      = trough_q;
    amp_d         = amp_q;
    locked_d      = locked_q;
    rv_d          = 1'b0;
    ovf_d         = 1'b0;
    if (sample_valid_i) begin
      if (rise) begin
        if (have_prev_q) begin
          period_d      = count_q;
          peak_d        = run_max_q;
          trough_d      = run_min_q;
          amp_d         = run_max_q - run_min_q;
          rv_d          = 1'b1;
          locked_d      = have_pp_q && (diff <= TOL);
          prev_period_d = count_q;
          have_pp_d     = 1'b1;
        end
        // The crossing sample seeds the new cycle.
        have_prev_d = 1'b1;
        count_d     = PERIOD_SIZE'(1);
        run_max_d   = sample_i;
        run_min_d   = sample_i;
      end else if (have_prev_q) begin
        if (ovf_now) begin
          ovf_d       = 1'b1;
          have_prev_d = 1'b0;
          have_pp_d   = 1'b0;
          locked_d    = 1'b0;
        end else begin
          count_d = count_q + 1'b1;
          if (sample_i > run_max_q) run_max_d = sample_i;
          if (sample_i < run_min_q) run_min_d = sample_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      have_prev_q   <= 1'b0;
      have_pp_q     <= 1'b0;
      count_q       <= '0;
      prev_period_q <= '0;
      run_max_q     <= '0;
      run_min_q     <= '0;
      period_q      <= '0;
      peak_q        <= '0;
      trough_q      <= '0;
      amp_q         <= '0;
      rv_q          <= 1'b0;
      locked_q      <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      have_prev_q   <= have_prev_d;
      have_pp_q     <= have_pp_d;
      count_q       <= count_d;
      prev_period_q <= prev_period_d;
      run_max_q     <= run_max_d;
      run_min_q     <= run_min_d;
      period_q      <= period_d;
      peak_q        <= peak_d;
      trough_q      <= trough_d;
      amp_q         <= amp_d;
      rv_q          <= rv_d;
      locked_q      <= locked_d;
      ovf_q         <= ovf_d;
    end
  end

  assign period_o       = period_q;
  assign peak_o         = peak_q;
  assign trough_o       = trough_q;
  assign amplitude_o    = amp_q;
  assign result_valid_o = rv_q;
  assign locked_o       = locked_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_sine_analyzer.sv
// Scoreboard bench for sine_analyzer: directed sample runs with hand-computed cycle results.
module tb_sine_analyzer;

  localparam int SS = 12;
  localparam int PS = 4;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          sample_valid_i = 1'b0;
  logic [SS-1:0] sample_i = '0;
  logic [PS-1:0] period_o;
  logic [SS-1:0] peak_o, trough_o, amplitude_o;
  logic          result_valid_o, locked_o, overflow_o;

  typedef struct {
    bit is_ovf;
    int period;
    int peak;
    int trough;
    int amp;
    int locked;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   rv_cnt = 0;
  int   ovf_cnt = 0;
  bit   gap = 1'b0;

  sine_analyzer #(
    .SINE_SIZE   (SS),
    .HYST        (16),
    .PERIOD_SIZE (PS),
    .LOCK_TOL    (1)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .sample_valid_i (sample_valid_i),
    .sample_i       (sample_i),
    .period_o       (period_o),
    .peak_o         (peak_o),
    .trough_o       (trough_o),
    .amplitude_o    (amplitude_o),
    .result_valid_o (result_valid_o),
    .locked_o       (locked_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".period"}, int'(period_o), 0);
    check({tag, ".peak"}, int'(peak_o), 0);
    check({tag, ".trough"}, int'(trough_o), 0);
    check({tag, ".amplitude"}, int'(amplitude_o), 0);
    check({tag, ".result_valid"}, int'(result_valid_o), 0);
    check({tag, ".locked"}, int'(locked_o), 0);
    check({tag, ".overflow"}, int'(overflow_o), 0);
  endtask

  task automatic send(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        @(negedge clk);
        sample_valid_i = 1'b0;
        sample_i       = SS'($urandom_range(0, 4095));
      end
      @(negedge clk);
      sample_valid_i = 1'b1;
      sample_i       = SS'(v);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_valid_i = 1'b0;
    end
  endtask

  task automatic exp_res(input int p, input int pk, input int tr, input int lk);
    exp_t e;
    e.is_ovf = 1'b0; e.period = p; e.peak = pk; e.trough = tr;
    e.amp = pk - tr; e.locked = lk;
    exp_q.push_back(e);
  endtask

  task automatic exp_ovf();
    exp_t e;
    e.is_ovf = 1'b1; e.period = 0; e.peak = 0; e.trough = 0; e.amp = 0; e.locked = 0;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sample_valid_i = 1'b0;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // Monitor: every result/overflow pulse is matched against the scoreboard head.
  always @(negedge clk) begin
    if (result_valid_o || overflow_o) begin
      exp_t e;
      if (result_valid_o) rv_cnt++;
      if (overflow_o) ovf_cnt++;
      check("rv_and_ovf_exclusive", int'(result_valid_o && overflow_o), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse_rv", int'(result_valid_o), 0);
        check("unexpected_pulse_ovf", int'(overflow_o), 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_is_overflow", int'(overflow_o), int'(e.is_ovf));
        if (!e.is_ovf) begin
          check("period", int'(period_o), e.period);
          check("peak", int'(peak_o), e.peak);
          check("trough", int'(trough_o), e.trough);
          check("amplitude", int'(amplitude_o), e.amp);
          check("locked", int'(locked_o), e.locked);
        end else begin
          check("ovf_locked_cleared", int'(locked_o), 0);
        end
      end
    end
  end

  initial begin
    int rv0, ovf0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_ni = 1'b1;

    // Square wave 5x0 / 5x4095, then a long high run that saturates the counter
    send(0, 5);
    send(4095, 5); send(0, 5);
    exp_res(10, 4095, 0, 0); send(4095, 5); send(0, 5);
    exp_res(10, 4095, 0, 1); send(4095, 5); send(0, 5);
    exp_res(10, 4095, 0, 1); send(4095, 15);
    exp_ovf(); send(4095, 4);
    idle(2);
    check("post_ovf.locked", int'(locked_o), 0);
    check("post_ovf.period_held", int'(period_o), 10);

    // Recovery with uneven levels, then 10/13 alternation, 10/11/10 lock, minimum period 2
    send(0, 5);
    send(2500, 1); send(3100, 2); send(2040, 1); send(900, 3); send(1000, 3);
    exp_res(10, 3100, 900, 0); send(3500, 7); send(500, 6);
    exp_res(13, 3500, 500, 0); send(4095, 5); send(0, 5);
    exp_res(10, 4095, 0, 0); send(4095, 7); send(0, 6);
    exp_res(13, 4095, 0, 0); send(4095, 5); send(0, 5);
    exp_res(10, 4095, 0, 0); send(4095, 6); send(0, 5);
    exp_res(11, 4095, 0, 1); send(4095, 5); send(0, 5);
    exp_res(10, 4095, 0, 1); send(4095, 1); send(0, 1);
    exp_res(2, 4095, 0, 0); send(4095, 1); send(0, 1);
    exp_res(2, 4095, 0, 1); send(4095, 1);
    idle(3);

    // Same square wave with an invalid cycle before every valid one
    do_reset();
    gap = 1'b1;
    send(0, 5);
    send(4095, 5); send(0, 5);
    exp_res(10, 4095, 0, 0); send(4095, 5); send(0, 5);
    exp_res(10, 4095, 0, 1); send(4095, 1);
    gap = 1'b0;
    idle(3);

    // Chatter inside the hysteresis band
    do_reset();
    rv0 = rv_cnt; ovf0 = ovf_cnt;
    for (int i = 0; i < 500; i++) begin
      send(2040, 1); send(2056, 1);
    end
    idle(3);
    check("chatter.result_count", rv_cnt - rv0, 0);
    check("chatter.overflow_count", ovf_cnt - ovf0, 0);

    // Asynchronous reset in the middle of the 3rd cycle
    do_reset();
    send(0, 5);
    send(4095, 5); send(0, 5);
    exp_res(10, 4095, 0, 0); send(4095, 5); send(0, 5);
    exp_res(10, 4095, 0, 1); send(4095, 5); send(0, 2);
    @(negedge clk);
    sample_valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    send(0, 3);
    send(4095, 5); send(0, 5);
    exp_res(10, 4095, 0, 0); send(4095, 5); send(0, 5);
    exp_res(10, 4095, 0, 1); send(4095, 1);
    idle(4);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
